// File: rtl/bht_ctrl.sv
// Branch history table controller: 2-bit saturating counters with init sweep,
// fetch lookups and EX updates. Optional gshare indexing under BHT_GSHARE_EN.
module bht_ctrl #(
   parameter int unsigned  ENTRIES = 64,
   parameter int unsigned  PC_W    = 32,
   localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   output logic             busy,
   input  logic             lookup_valid,
   input  logic [PC_W-1:0]  lookup_pc,
   output logic             lookup_ready,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [IDX_W-1:0] pred_idx,
   input  logic             update_valid,
   input  logic [IDX_W-1:0] update_idx,
   input  logic             update_taken,
   output logic             update_ready
);

   typedef enum logic {INIT, RUN} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [1:0]       ctr_q [ENTRIES];
   logic [1:0]       ctr_d [ENTRIES];
   logic             pred_valid_q, pred_valid_d;
   logic             pred_taken_q, pred_taken_d;
   logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
   logic [IDX_W-1:0] lookup_idx;
   logic             lookup_acc;
   logic             update_acc;

`ifdef BHT_GSHARE_EN
   logic [IDX_W-1:0] ghr_q, ghr_d;
`endif

   logic unused_pc;
   assign unused_pc = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

   function automatic logic [1:0] sat_next(input logic [1:0] c, input logic taken);
      if (taken) return (c == 2'b11) ? c : c + 2'd1;
      else       return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   // Next-state, table write and prediction logic
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      ctr_d        = ctr_q;
      pred_valid_d = 1'b0;
      pred_taken_d = pred_taken_q;
      pred_idx_d   = pred_idx_q;
      busy         = 1'b0;
      lookup_ready = 1'b0;
      update_ready = 1'b0;
`ifdef BHT_GSHARE_EN
      ghr_d        = ghr_q;
      lookup_idx   = lookup_pc[IDX_W+1:2] ^ ghr_q;
`else
      lookup_idx   = lookup_pc[IDX_W+1:2];
`endif

      case (state_q)
         INIT: begin
            busy = 1'b1;
            if (flush) begin
               ptr_d = '0;
            end else begin
               ctr_d[ptr_q] = 2'b01;
               ptr_d        = ptr_q + IDX_W'(1);
               if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_d = INIT;
               ptr_d   = '0;
            end else begin
               lookup_ready = 1'b1;
               update_ready = 1'b1;
            end
         end
         default: state_d = INIT;
      endcase

      lookup_acc = lookup_valid & lookup_ready;
      update_acc = update_valid & update_ready;

      if (update_acc) begin
         ctr_d[update_idx] = sat_next(ctr_q[update_idx], update_taken);
`ifdef BHT_GSHARE_EN
         ghr_d = {ghr_q[IDX_W-2:0], update_taken};
`endif
      end

      // Reading ctr_d forwards a same-cycle update to the prediction
      if (lookup_acc) begin
         pred_valid_d = 1'b1;
         pred_taken_d = ctr_d[lookup_idx][1];
         pred_idx_d   = lookup_idx;
      end

`ifdef BHT_GSHARE_EN
      if (flush) ghr_d = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= INIT;
         ptr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_idx_q   <= '0;
`ifdef BHT_GSHARE_EN
         ghr_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         pred_idx_q   <= pred_idx_d;
`ifdef BHT_GSHARE_EN
         ghr_q        <= ghr_d;
`endif
      end
   end

   // Counter storage has no reset; the init sweep defines it
   always_ff @(posedge clk) begin
      ctr_q <= ctr_d;
   end

   assign pred_valid = pred_valid_q;
   assign pred_taken = pred_taken_q;
   assign pred_idx   = pred_idx_q;

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed scoreboard bench for bht_ctrl; a reference counter model predicts
// every lookup result, which is queued and compared one cycle after acceptance.
module tb_bht_ctrl;

   localparam int unsigned ENTRIES = 64;
   localparam int unsigned IDX_W   = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             busy;
   logic             lookup_valid;
   logic [31:0]      lookup_pc;
   logic             lookup_ready;
   logic             pred_valid;
   logic             pred_taken;
   logic [IDX_W-1:0] pred_idx;
   logic             update_valid;
   logic [IDX_W-1:0] update_idx;
   logic             update_taken;
   logic             update_ready;

   bht_ctrl #(.ENTRIES(ENTRIES), .PC_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .busy         (busy),
      .lookup_valid (lookup_valid),
      .lookup_pc    (lookup_pc),
      .lookup_ready (lookup_ready),
      .pred_valid   (pred_valid),
      .pred_taken   (pred_taken),
      .pred_idx     (pred_idx),
      .update_valid (update_valid),
      .update_idx   (update_idx),
      .update_taken (update_taken),
      .update_ready (update_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             taken;
      logic [IDX_W-1:0] idx;
   } exp_t;

   exp_t             sb [$];
   logic [1:0]       mdl [ENTRIES];
   logic [IDX_W-1:0] ghr_m;
   logic             last_taken;
   logic [IDX_W-1:0] last_idx;
   int               vectors = 0;
   int               miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
      if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
      return (c == 2'b00) ? 2'b00 : c - 2'd1;
   endfunction

   // One clock: update the model from what is accepted, then check outputs
   task automatic tick();
      logic             l_acc;
      logic             u_acc;
      logic [IDX_W-1:0] lidx;
      exp_t             e;
      l_acc = lookup_valid && (lookup_ready === 1'b1);
      u_acc = update_valid && (update_ready === 1'b1);
      lidx  = lookup_pc[IDX_W+1:2];
`ifdef BHT_GSHARE_EN
      lidx  = lidx ^ ghr_m;
`endif
      if (reset || flush) begin
         for (int i = 0; i < ENTRIES; i++) mdl[i] = 2'b01;
         ghr_m = '0;
         if (reset) begin
            last_taken = 1'b0;
            last_idx   = '0;
         end
      end else begin
         if (u_acc) begin
            mdl[update_idx] = sat(mdl[update_idx], update_taken);
            ghr_m = {ghr_m[IDX_W-2:0], update_taken};
         end
         if (l_acc) begin
            e.taken = mdl[lidx][1];
            e.idx   = lidx;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("pred_valid", 32'(pred_valid), 32'd1);
         chk("pred_taken", 32'(pred_taken), 32'(e.taken));
         chk("pred_idx",   32'(pred_idx),   32'(e.idx));
         last_taken = e.taken;
         last_idx   = e.idx;
      end else begin
         chk("pred_valid_idle", 32'(pred_valid), 32'd0);
         chk("pred_taken_hold", 32'(pred_taken), 32'(last_taken));
         chk("pred_idx_hold",   32'(pred_idx),   32'(last_idx));
      end
   endtask

   task automatic wait_init(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         chk({tag, "_lookup_ready"}, 32'(lookup_ready), 32'd0);
         tick();
         n++;
      end
      chk({tag, "_len"}, 32'(n), 32'(ENTRIES));
      chk({tag, "_ready_after"}, 32'({lookup_ready, update_ready}), 32'd3);
   endtask

   task automatic do_lookup(input logic [31:0] pc);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      tick();
      lookup_valid = 1'b0;
   endtask

   task automatic do_update(input logic [IDX_W-1:0] idx, input logic t);
      update_valid = 1'b1;
      update_idx   = idx;
      update_taken = t;
      tick();
      update_valid = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      flush        = 1'b0;
      lookup_valid = 1'b0;
      lookup_pc    = '0;
      update_valid = 1'b0;
      update_idx   = '0;
      update_taken = 1'b0;
      ghr_m        = '0;
      last_taken   = 1'b0;
      last_idx     = '0;

      // Reset state
      tick();
      chk("rst_busy",         32'(busy),         32'd1);
      chk("rst_lookup_ready", 32'(lookup_ready), 32'd0);
      chk("rst_update_ready", 32'(update_ready), 32'd0);
      reset = 1'b0;
      wait_init("init");

      // Fresh table predicts not-taken everywhere
      do_lookup(32'h0000_0000);
      do_lookup(32'h0000_0014);
      do_lookup(32'h0000_00FC);
      do_lookup(32'h1234_5678);

      // Up-saturation then down-saturation on idx 5
      for (int i = 0; i < 4; i++) begin
         do_update(6'd5, 1'b1);
         do_lookup(32'h0000_0014);
      end
      for (int i = 0; i < 4; i++) begin
         do_update(6'd5, 1'b0);
         do_lookup(32'h0000_0014);
      end

      // Same-cycle collision on idx 9 forwards the update
      lookup_valid = 1'b1;
      lookup_pc    = 32'h0000_0024;
      update_valid = 1'b1;
      update_idx   = 6'd9;
      update_taken = 1'b1;
      tick();
      lookup_valid = 1'b0;
      update_valid = 1'b0;
      tick();

      // Collision on different indices stays independent
      lookup_valid = 1'b1;
      lookup_pc    = 32'h0000_0030;
      update_valid = 1'b1;
      update_idx   = 6'd9;
      update_taken = 1'b1;
      tick();
      lookup_valid = 1'b0;
      update_valid = 1'b0;
      do_lookup(32'h0000_0024);

      // Train idx 3, then flush right after an accepted lookup
      for (int i = 0; i < 3; i++) do_update(6'd3, 1'b1);
      do_lookup(32'h0000_000C);
      lookup_valid = 1'b1;
      lookup_pc    = 32'h0000_000C;
      flush        = 1'b1;
      #1;
      chk("flush_lookup_ready", 32'(lookup_ready), 32'd0);
      chk("flush_update_ready", 32'(update_ready), 32'd0);
      tick();
      flush        = 1'b0;
      lookup_valid = 1'b0;
      update_valid = 1'b1;
      update_idx   = 6'd3;
      update_taken = 1'b1;
      wait_init("flush");
      update_valid = 1'b0;
      do_lookup(32'h0000_000C);

      // Global history feeds the index in the gshare build
      do_update(6'd20, 1'b1);
      do_update(6'd21, 1'b1);
      do_lookup(32'h0000_0000);
      do_lookup(32'h0000_0044);

      // Reset mid-operation clears a pending prediction
      lookup_valid = 1'b1;
      lookup_pc    = 32'h0000_0008;
      tick();
      reset = 1'b1;
      tick();
      reset        = 1'b0;
      lookup_valid = 1'b0;
      wait_init("reinit");
      do_lookup(32'h0000_0014);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
